// File: rtl/lcd_bus_timer.sv
// HD44780 parallel-bus timer: accepts one RS/byte transfer at a time and
// sequences setup, enable pulse, hold and command execution wait.
module lcd_bus_timer #(
  parameter int T_POR       = 750000,
  parameter int T_SETUP     = 4,
  parameter int T_EN        = 25,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_dat,
  output logic       busy
);

  // The shared counter must hold the largest phase length, never fewer than 20 bits.
  localparam int M1     = (T_POR > T_EXEC_LONG) ? T_POR : T_EXEC_LONG;
  localparam int M2     = (T_EXEC > T_EN) ? T_EXEC : T_EN;
  localparam int M3     = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int M12    = (M1 > M2) ? M1 : M2;
  localparam int MAXT   = (M12 > M3) ? M12 : M3;
  localparam int CW_RAW = $clog2(MAXT + 1);
  localparam int CW     = (CW_RAW > 20) ? CW_RAW : 20;

  typedef enum logic [2:0] {
    POR_WAIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_en;
  logic            r_rs;
  logic [7:0]      r_dat;

  logic            w_longExec;
  logic [CW-1:0]   w_execLast;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign w_longExec = ~r_rs && ((r_dat == 8'h01) || (r_dat == 8'h02) || (r_dat == 8'h03));
  assign w_execLast = w_longExec ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);

  assign in_ready = r_ready;
  assign busy     = ~r_ready;
  assign lcd_en   = r_en;
  assign lcd_rs   = r_rs;
  assign lcd_dat  = r_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= POR_WAIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_dat   <= 8'h00;
    end else begin
      case (r_state)
        // The reset edge already counts as entry, so the wait ends one count later.
        POR_WAIT: begin
          if (r_cnt == CW'(T_POR)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (in_valid && r_ready) begin
            r_state <= SETUP;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_rs    <= in_rs;
            r_dat   <= in_data;
          end
        end
        SETUP: begin
          if (r_cnt == CW'(T_SETUP - 1)) begin
            r_state <= PULSE;
            r_cnt   <= '0;
            r_en    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PULSE: begin
          if (r_cnt == CW'(T_EN - 1)) begin
            r_state <= HOLD;
            r_cnt   <= '0;
            r_en    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (r_cnt == CW'(T_HOLD - 1)) begin
            r_state <= EXEC;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        EXEC: begin
          if (r_cnt == w_execLast) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= POR_WAIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_timer.sv
// Scoreboard bench for lcd_bus_timer: stimulus queues the expected transfer,
// a negedge monitor times each enable pulse and ready return against it.
module tb_lcd_bus_timer;

  localparam int T_POR       = 10;
  localparam int T_SETUP     = 2;
  localparam int T_EN        = 3;
  localparam int T_HOLD      = 1;
  localparam int T_EXEC      = 5;
  localparam int T_EXEC_LONG = 20;

  localparam int EN_FIRST = 3;
  localparam int EN_LAST  = 5;
  localparam int EN_COUNT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       lcd_rs;
  logic       lcd_en;
  logic [7:0] lcd_dat;
  logic       busy;

  typedef struct {
    logic       rs;
    logic [7:0] dat;
    int         readyCyc;
    int         gap;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  lcd_bus_timer #(
    .T_POR(T_POR), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_data(in_data), .lcd_rs(lcd_rs), .lcd_en(lcd_en),
    .lcd_dat(lcd_dat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Queue the expectation, offer the byte, then optionally churn inputs while busy.
  task automatic applyStimulus(input logic rs, input logic [7:0] data, input int readyCyc,
                               input int gap, input bit keepValid, input bit scramble);
    exp_t e;
    bit   got;
    e.rs = rs; e.dat = data; e.readyCyc = readyCyc; e.gap = gap;
    expQ.push_back(e);
    in_rs = rs;
    in_data = data;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) failNow("acceptTimeout");
    @(posedge clk);
    #1;
    if (!keepValid) in_valid = 1'b0;
    if (scramble) begin
      for (int i = 0; i < 100; i++) begin
        in_data = 8'($urandom);
        in_rs = 1'($urandom);
        @(posedge clk);
        #1;
        if (in_ready === 1'b1) break;
      end
    end
  endtask

  int         globalCycle = 0;
  int         lastAccept = 0;
  int         rel = 0;
  int         enFirst = 0;
  int         enLast = 0;
  int         enCount = 0;
  int         porCnt = 0;
  bit         tracking = 0;
  bit         pending = 0;
  bit         rstPrev = 0;
  bit         armed = 0;
  bit         inPor = 0;
  exp_t       cur;
  logic       modelRs = 1'b0;
  logic [7:0] modelDat = 8'h00;

  // Monitor: the edge just before this negedge was a reset edge when rstPrev is set.
  initial begin
    forever begin
      @(negedge clk);
      globalCycle++;
      if (rstPrev) begin
        armed = 1; tracking = 0; pending = 0; inPor = 1; porCnt = 0;
        modelRs = 1'b0; modelDat = 8'h00;
        checkOutput("resetState", {20'b0, in_ready, busy, lcd_en, lcd_rs, lcd_dat}, 32'h400);
      end else if (armed) begin
        if (inPor) begin
          porCnt++;
          if (in_ready === 1'b1) begin
            checkOutput("porReadyCycle", porCnt, T_POR + 1);
            inPor = 0;
          end else if (porCnt > T_POR + 10) begin
            failNow("porTimeout");
            inPor = 0;
          end
        end
        if (pending) begin
          if (expQ.size() == 0) begin
            failNow("unexpectedAccept");
          end else begin
            cur = expQ.pop_front();
            tracking = 1; rel = 0; enFirst = 0; enLast = 0; enCount = 0;
            modelRs = cur.rs; modelDat = cur.dat;
            if (cur.gap != 0) checkOutput("acceptGap", globalCycle - lastAccept, cur.gap);
          end
          lastAccept = globalCycle;
        end
        if (tracking) begin
          rel++;
          if (lcd_en === 1'b1) begin
            if (enFirst == 0) enFirst = rel;
            enLast = rel;
            enCount++;
          end
          if (in_ready === 1'b1) begin
            checkOutput("enRise", enFirst, EN_FIRST);
            checkOutput("enFall", enLast, EN_LAST);
            checkOutput("enHigh", enCount, EN_COUNT);
            checkOutput("readyCycle", rel, cur.readyCyc);
            tracking = 0;
          end else if (rel > 100) begin
            failNow("readyTimeout");
            tracking = 0;
          end
        end else begin
          checkOutput("enIdle", {31'b0, lcd_en}, 0);
        end
        checkOutput("busyInv", {31'b0, busy}, {31'b0, ~in_ready});
        checkOutput("lcdDat", {24'b0, lcd_dat}, {24'b0, modelDat});
        checkOutput("lcdRs", {31'b0, lcd_rs}, {31'b0, modelRs});
        pending = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst === 1'b0);
      end
      rstPrev = (rst === 1'b1);
    end
  end

  initial begin
    bit seen;
    rst = 1'b1;
    in_valid = 1'b1;
    in_rs = 1'b1;
    in_data = 8'h41;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] single transfers");
    applyStimulus(1'b1, 8'h41, 12, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h01, 27, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h0C, 12, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 12, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h01, 12, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h02, 27, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h03, 27, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h04, 12, 0, 1'b0, 1'b1);

    $display("[TB] back-to-back stream");
    applyStimulus(1'b0, 8'h38, 12, 0,  1'b1, 1'b0);
    applyStimulus(1'b0, 8'h0C, 12, 12, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h47, 12, 12, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h4F, 12, 12, 1'b0, 1'b1);

    $display("[TB] reset during enable pulse");
    applyStimulus(1'b1, 8'h55, 12, 0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lcd_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) failNow("pulseTimeout");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 8'h80, 12, 0, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 0);
    checkOutput("drained", {31'b0, tracking}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lcd_bus_timer.md
LCD_BUS_TIMER -- requirements
Module: lcd_bus_timer

Interface
REQ-001 Parameter T_POR, default 750000, gives the power-on wait in clk cycles (15 ms at 50 MHz).
REQ-002 Parameter T_SETUP, default 4, gives the RS/DAT-to-EN-rise setup time in cycles.
REQ-003 Parameter T_EN, default 25, gives the EN high width in cycles.
REQ-004 Parameter T_HOLD, default 2, gives the EN-fall-to-next-change hold time in cycles.
REQ-005 Parameter T_EXEC, default 2000, gives the execution wait for normal commands and data in cycles (40 us).
REQ-006 Parameter T_EXEC_LONG, default 82000, gives the execution wait for clear and home commands in cycles (1.64 ms).
REQ-007 Port clk, input, width 1, is the single clock; all logic is on the posedge.
REQ-008 Port rst, input, width 1, is a synchronous, active-high reset.
REQ-009 Port in_valid, input, width 1, indicates the upstream byte is valid.
REQ-010 Port in_ready, output, width 1, indicates the block will accept a byte this cycle.
REQ-011 Port in_rs, input, width 1, carries the register select: 0 = command, 1 = data.
REQ-012 Port in_data, input, width 8, carries the command or character byte.
REQ-013 Port lcd_rs, output, width 1, drives the HD44780 RS pin.
REQ-014 Port lcd_en, output, width 1, drives the HD44780 E pin.
REQ-015 Port lcd_dat, output, width 8, drives the HD44780 DB7..DB0 pins.
REQ-016 Port busy, output, width 1, SHALL equal ~in_ready at all times.

Function
REQ-017 The FSM SHALL have exactly these states: POR_WAIT, IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-018 All parameters SHALL be >= 1; one shared down/up counter SHALL be at least 20 bits wide.
REQ-019 POR_WAIT SHALL last T_POR cycles, then go to IDLE; in_ready is 0 throughout.
REQ-020 in_ready SHALL be 1 only in IDLE and SHALL be registered, with no combinational path from in_valid.
REQ-021 A transfer SHALL be accepted on the edge where in_valid and in_ready are both 1; in_rs and in_data are then captured into lcd_rs and lcd_dat on that edge.
REQ-022 lcd_rs and lcd_dat SHALL remain stable from acceptance until the next acceptance, including through EXEC and IDLE.
REQ-023 In_data and in_rs activity while no transfer is accepted SHALL have no effect on the outputs.
REQ-024 Taking the acceptance edge as cycle 0: cycles 1..T_SETUP are SETUP with lcd_en=0.
REQ-025 The next T_EN cycles are PULSE with lcd_en=1.
REQ-026 The next T_HOLD cycles are HOLD with lcd_en=0.
REQ-027 The next Texec cycles are EXEC with lcd_en=0.
REQ-028 IDLE with in_ready=1 SHALL follow in cycle T_SETUP+T_EN+T_HOLD+Texec+1.
REQ-029 Texec SHALL be T_EXEC_LONG when the captured rs=0 and data is 0x01, 0x02 or 0x03; otherwise Texec SHALL be T_EXEC, including all rs=1 bytes and command 0x00.
REQ-030 lcd_en SHALL be driven from a register and SHALL be glitch-free.
REQ-031 Back-to-back: with in_valid held high, the next byte SHALL be accepted on the first IDLE edge, with no extra idle cycle.
REQ-032 The block SHALL not buffer bytes; in_valid while in_ready=0 is simply not accepted, and upstream holds its byte.

Reset
REQ-033 While rst=1 at an edge, the block SHALL set state=POR_WAIT, counter=0, lcd_en=0, lcd_rs=0, lcd_dat=8'h00, in_ready=0 and busy=1.
REQ-034 rst asserted mid-transfer SHALL drop lcd_en to 0 on that edge, abandon the byte and restart the full T_POR wait.
REQ-035 in_ready SHALL first rise in cycle T_POR+1 counted from the first edge with rst=0.

Verification (parameters T_POR=10, T_SETUP=2, T_EN=3, T_HOLD=1, T_EXEC=5, T_EXEC_LONG=20)
REQ-036 Release rst with in_valid=1 -> in_ready=0 for cycles 1..10 and 1 in cycle 11; no lcd_en activity before that.
REQ-037 Accept rs=1, data=0x41 -> lcd_dat=0x41 and lcd_rs=1 from cycle 1; lcd_en=1 exactly in cycles 3-5; in_ready=1 in cycle 12.
REQ-038 Accept rs=0, data=0x01 -> lcd_en high in cycles 3-5; in_ready returns in cycle 27; the same test with 0x0C returns in cycle 12.
REQ-039 Stream 0x38, 0x0C, "G", "O" with in_valid held high -> acceptances exactly 12 cycles apart.
REQ-040 Change in_data each cycle while busy -> lcd_dat never changes except at acceptance edges.
REQ-041 Assert rst during PULSE -> lcd_en=0 at the next edge, and in_ready stays 0 for 10 cycles after rst release.
